// File: rtl/dsp48a1_mac_sequencer.sv
// Drives one DSP48A1 slice as a multiply-accumulate engine.
// Commands stream A/B pairs; the drained P is returned on a valid/ready port.
module dsp48a1_mac_sequencer #(
    parameter int LEN_W    = 16,
    parameter int PIPE_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_use_init,
    input  logic [47:0]      cmd_init,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [17:0]      op_a,
    input  logic [17:0]      op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data,
    output logic             busy,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [17:0]      dsp_d,
    output logic [47:0]      dsp_c,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_ce,
    output logic             dsp_rst,
    input  logic [47:0]      dsp_p
);

    typedef enum logic [2:0] {
        RSTCLR, IDLE, PRIME, ACCUM, DRAIN, RESULT
    } state_t;

    localparam int         CNT_W     = $clog2(PIPE_LAT + 1) + 1;
    localparam logic [7:0] OPM_FIRST = 8'h0D;
    localparam logic [7:0] OPM_ACC   = 8'h09;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [LEN_W-1:0] rem, rem_n;
    logic             use_init_q;
    logic [47:0]      init_q;
    logic             first_d;
    logic             op_take;
    logic             drain_done;

    assign op_take    = (state == ACCUM) && op_valid;
    assign drain_done = (state == DRAIN) && (cnt == CNT_W'(PIPE_LAT));

    assign cmd_ready = (state == IDLE);
    assign op_ready  = (state == ACCUM);
    assign busy      = (state != IDLE);
    assign dsp_d     = '0;
    assign dsp_rst   = (state == RSTCLR);
    // The slice stays frozen while rst is held, then clears during RSTCLR.
    assign dsp_ce    = !rst && (state == RSTCLR || state == PRIME ||
                                state == ACCUM  || state == DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RSTCLR;
            cnt   <= '0;
            rem   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            rem   <= rem_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rem_n   = rem;
        unique case (state)
            RSTCLR: begin
                if (cnt == CNT_W'(1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            IDLE: begin
                if (cmd_valid) begin
                    rem_n   = cmd_len;
                    state_n = PRIME;
                end
            end
            PRIME: begin
                cnt_n   = '0;
                state_n = (rem != '0) ? ACCUM : DRAIN;
            end
            ACCUM: begin
                if (op_valid) begin
                    rem_n = rem - LEN_W'(1);
                    if (rem == LEN_W'(1)) state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_n = RESULT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            RESULT: begin
                if (res_ready) state_n = IDLE;
            end
            default: state_n = RSTCLR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            use_init_q <= 1'b0;
            init_q     <= '0;
            dsp_a      <= '0;
            dsp_b      <= '0;
            dsp_c      <= '0;
            dsp_opmode <= '0;
            first_d    <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                use_init_q <= cmd_use_init;
                init_q     <= cmd_init;
            end
            // Non-accepted cycles become zero-product bubbles.
            dsp_a <= op_take ? op_a : '0;
            dsp_b <= op_take ? op_b : '0;
            if (state == PRIME) dsp_c <= use_init_q ? init_q : '0;
            // Opmode lags operands by one cycle to meet the slice M stage.
            first_d    <= (state == PRIME);
            dsp_opmode <= first_d ? OPM_FIRST : OPM_ACC;
            if (drain_done) begin
                res_valid <= 1'b1;
                res_data  <= dsp_p;
            end else if (state == RESULT && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Bench for dsp48a1_mac_sequencer with a behavioural DSP48A1 slice model.
// Directed command vectors plus reset and backpressure sequences.
module tb_dsp48a1_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_len = '0;
    logic        cmd_use_init = 1'b0;
    logic [47:0] cmd_init = '0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [17:0] op_a = '0;
    logic [17:0] op_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [47:0] res_data;
    logic        busy;
    logic [17:0] dsp_a, dsp_b, dsp_d;
    logic [47:0] dsp_c;
    logic [7:0]  dsp_opmode;
    logic        dsp_ce, dsp_rst;
    logic [47:0] dsp_p;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dsp48a1_mac_sequencer #(.LEN_W(16), .PIPE_LAT(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .cmd_use_init(cmd_use_init),
        .cmd_init(cmd_init),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .busy(busy),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c),
        .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce), .dsp_rst(dsp_rst),
        .dsp_p(dsp_p)
    );

    // Slice model: A1/B1, M, P, C and OPMODE registers, sync reset.
    logic [17:0] s_a1, s_b1;
    logic [47:0] s_m, s_c, s_p, s_x, s_z;
    logic [7:0]  s_opm;

    always_comb begin
        s_x = (s_opm[1:0] == 2'b01) ? s_m : 48'd0;
        case (s_opm[3:2])
            2'b10:   s_z = s_p;
            2'b11:   s_z = s_c;
            default: s_z = 48'd0;
        endcase
    end

    always @(posedge clk) begin
        if (dsp_rst) begin
            s_a1 <= '0; s_b1 <= '0; s_m <= '0;
            s_c <= '0; s_p <= '0; s_opm <= '0;
        end else if (dsp_ce) begin
            s_a1  <= dsp_a;
            s_b1  <= dsp_b;
            s_m   <= 48'(s_a1) * 48'(s_b1);
            s_c   <= dsp_c;
            s_opm <= dsp_opmode;
            s_p   <= s_opm[7] ? s_z - s_x : s_z + s_x;
        end
    end
    assign dsp_p = s_p;

    typedef struct packed {
        logic [15:0]      len;
        logic             use_init;
        logic [47:0]      init;
        logic [3:0][17:0] a;
        logic [3:0][17:0] b;
        logic [3:0]       gap;
        logic [3:0]       hold;
        logic [47:0]      exp;
    } vec_t;

    function automatic vec_t mk(
        input logic [15:0] len, input logic ui, input logic [47:0] init,
        input logic [17:0] a0, b0, a1, b1, a2, b2, a3, b3,
        input logic [3:0] gap, hold, input logic [47:0] exp);
        vec_t v;
        v.len = len; v.use_init = ui; v.init = init;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
        v.gap = gap; v.hold = hold; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic run_cmd(input vec_t v);
        int n;
        int t0;
        logic [47:0] held;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_len = v.len;
        cmd_use_init = v.use_init;
        cmd_init = v.init;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("cmd_accept", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_init = 48'hDEAD_BEEF_0000;
        t0 = cyc;
        for (int i = 0; i < int'(v.len); i++) begin
            if (i > 0) begin
                op_valid = 1'b0;
                repeat (int'(v.gap)) @(negedge clk);
            end
            op_valid = 1'b1;
            op_a = v.a[i];
            op_b = v.b[i];
            n = 0;
            while (!op_ready && n < 50) begin @(negedge clk); n++; end
            chk("op_accept", 64'(op_ready), 64'd1);
            @(negedge clk);
        end
        op_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 60) begin @(negedge clk); n++; end
        chk("res_valid", 64'(res_valid), 64'd1);
        if (v.gap == 4'd0)
            chk("latency", 64'(cyc - t0 + 1), 64'(v.len) + 64'd6);
        chk("res_data", 64'(res_data), 64'(v.exp));
        chk("res_cmd_ready", 64'(cmd_ready), 64'd0);
        held = res_data;
        repeat (int'(v.hold)) begin
            @(negedge clk);
            chk("hold_valid", 64'(res_valid), 64'd1);
            chk("hold_data", 64'(res_data), 64'(held));
            chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_drop", 64'(res_valid), 64'd0);
        chk("back_idle", 64'(cmd_ready), 64'd1);
    endtask

    vec_t tbl [6];
    vec_t post_rst;

    initial begin
        tbl[0] = mk(16'd4, 1'b0, 48'd0, 18'd1, 18'd2, 18'd3, 18'd4,
                    18'd5, 18'd6, 18'd7, 18'd8, 4'd0, 4'd0, 48'd100);
        tbl[1] = mk(16'd3, 1'b1, 48'd1000, 18'd10, 18'd10, 18'd20, 18'd5,
                    18'd3, 18'd3, 18'd0, 18'd0, 4'd2, 4'd0, 48'd1209);
        tbl[2] = mk(16'd0, 1'b1, 48'h1234_5678_9ABC, 18'd0, 18'd0, 18'd0,
                    18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 4'd0, 4'd5,
                    48'h1234_5678_9ABC);
        tbl[3] = mk(16'd1, 1'b1, 48'hFFFF_FFFF_FFFF, 18'd1, 18'd1, 18'd0,
                    18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 4'd0, 4'd0, 48'd0);
        tbl[4] = mk(16'd2, 1'b0, 48'd0, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF,
                    18'h3FFFF, 18'd0, 18'd0, 18'd0, 18'd0, 4'd0, 4'd1,
                    48'h1F_FFF0_0002);
        tbl[5] = mk(16'd2, 1'b0, 48'hABC, 18'd2, 18'd3, 18'd4, 18'd5,
                    18'd0, 18'd0, 18'd0, 18'd0, 4'd1, 4'd0, 48'd26);
        post_rst = mk(16'd1, 1'b0, 48'd0, 18'd2, 18'd3, 18'd0, 18'd0,
                      18'd0, 18'd0, 18'd0, 18'd0, 4'd0, 4'd0, 48'd6);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_dsp_rst", 64'(dsp_rst), 64'd1);
            chk("rst_dsp_ce", 64'(dsp_ce), 64'd0);
            chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("rst_busy", 64'(busy), 64'd1);
            chk("rst_res_valid", 64'(res_valid), 64'd0);
            chk("rst_opmode", 64'(dsp_opmode), 64'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("clr_dsp_rst", 64'(dsp_rst), 64'd1);
            chk("clr_dsp_ce", 64'(dsp_ce), 64'd1);
            chk("clr_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        @(negedge clk);
        chk("idle_dsp_rst", 64'(dsp_rst), 64'd0);
        chk("idle_dsp_ce", 64'(dsp_ce), 64'd0);
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("dsp_d_zero", 64'(dsp_d), 64'd0);

        for (int i = 0; i < 6; i++) run_cmd(tbl[i]);

        // Abort a 4-beat command after two beats.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = 16'd4;
        cmd_use_init = 1'b1; cmd_init = 48'd555;
        @(negedge clk);
        cmd_valid = 1'b0;
        op_valid = 1'b1; op_a = 18'd9; op_b = 18'd9;
        @(negedge clk);
        chk("accum_op_ready", 64'(op_ready), 64'd1);
        chk("accum_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("accum_busy", 64'(busy), 64'd1);
        @(negedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_dsp_rst", 64'(dsp_rst), 64'd1);
        chk("abort_dsp_ce", 64'(dsp_ce), 64'd0);
        chk("abort_res_valid", 64'(res_valid), 64'd0);
        chk("abort_dsp_a", 64'(dsp_a), 64'd0);
        chk("abort_cmd_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        op_valid = 1'b1; op_a = 18'd1000; op_b = 18'd1000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_op_ready", 64'(op_ready), 64'd0);
        end
        op_valid = 1'b0;
        run_cmd(post_rst);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
